// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage controller and the ALU it feeds:
// opcodes, flag bit positions, flag mask and the controller FSM encoding.
package alu_pkg;

    localparam int DATA_W = 8;

    // 4-bit ALU opcodes
    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_OR     = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd2;
    localparam logic [3:0] OP_NOT    = 4'd3;
    localparam logic [3:0] OP_ADD    = 4'd4;
    localparam logic [3:0] OP_SUB    = 4'd5;
    localparam logic [3:0] OP_NEG    = 4'd6;
    localparam logic [3:0] OP_INC    = 4'd7;
    localparam logic [3:0] OP_DEC    = 4'd8;
    localparam logic [3:0] OP_SHL    = 4'd9;
    localparam logic [3:0] OP_SHR    = 4'd10;
    localparam logic [3:0] OP_MIRROR = 4'd11;

    // Flag bit indices in the ALU flag byte
    localparam int FLAG_CARRY     = 0;
    localparam int FLAG_AUX_CARRY = 1;
    localparam int FLAG_ZERO      = 2;
    localparam int FLAG_SIGN      = 3;
    localparam int FLAG_PARITY    = 4;
    localparam int FLAG_OVERFLOW  = 5;

    // Bits [7:6] of the captured flags always read 0
    localparam logic [7:0] FLAG_MASK = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } exec_state_e;

endpackage

// File: rtl/alu_regfile.sv
// General-purpose register file for the execute controller.
// Ports: clk_i/rst_i (async high), we_i/waddr_i/wdata_i single write port,
// three combinational reads: ra1_i->rd1_o, ra2_i->rd2_o, ra3_i->rd3_o.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 4,
    parameter int ADDR_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra1_i,
    output logic [DATA_W-1:0] rd1_o,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd2_o,
    input  logic [ADDR_W-1:0] ra3_i,
    output logic [DATA_W-1:0] rd3_o
);

    logic [DATA_W-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd1_o = mem_q[ra1_i];
    assign rd2_o = mem_q[ra2_i];
    assign rd3_o = mem_q[ra3_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: fetches operands into registered ALU inputs,
// captures the ALU result/flags and writes the result back to the regfile.
// Ports: clk_i, rst_i (async high); issue: start_i, op_i, rd_i, rs1_i, rs2_i,
// imm_en_i, imm_i, no_wb_i; preload: ld_en_i, ld_addr_i, ld_data_i;
// debug: rd_addr_i -> rd_data_o; status: busy_o, done_o;
// ALU side: alu_a_o, alu_b_o, alu_op_o out, alu_c_i, alu_flags_i in;
// last capture: result_o, flags_o.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 4,
    parameter int ADDR_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    input  logic              imm_en_i,
    input  logic [7:0]        imm_i,
    input  logic              no_wb_i,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        alu_a_o,
    output logic [7:0]        alu_b_o,
    output logic [3:0]        alu_op_o,
    input  logic [7:0]        alu_c_i,
    input  logic [7:0]        alu_flags_i,
    output logic [7:0]        result_o,
    output logic [7:0]        flags_o
);

    exec_state_e state_q, state_d;

    // Instruction fields latched at issue
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic              imm_en_q;
    logic [7:0]        imm_q;
    logic              no_wb_q;

    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [3:0] alu_op_q;
    logic [7:0] result_q;
    logic [7:0] flags_q;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [7:0]        rf_wdata;
    logic [7:0]        rs1_data;
    logic [7:0]        rs2_data;

    alu_regfile #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .ra1_i   (rs1_q),
        .rd1_o   (rs1_data),
        .ra2_i   (rs2_q),
        .rd2_o   (rs2_data),
        .ra3_i   (rd_addr_i),
        .rd3_o   (rd_data_o)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
        endcase
    end

    // Outputs and write-port arbitration: preload owns the port in IDLE,
    // write-back owns it in WB, so the two can never collide.
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = ld_addr_i;
        rf_wdata = ld_data_i;
        unique case (state_q)
            ST_IDLE: begin
                rf_we = ld_en_i;
            end
            ST_FETCH, ST_EXEC: begin
                busy_o = 1'b1;
            end
            ST_WB: begin
                busy_o   = 1'b1;
                done_o   = 1'b1;
                rf_we    = ~no_wb_q;
                rf_waddr = rd_q;
                rf_wdata = result_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            no_wb_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                op_q     <= op_i;
                rd_q     <= rd_i;
                rs1_q    <= rs1_i;
                rs2_q    <= rs2_i;
                imm_en_q <= imm_en_i;
                imm_q    <= imm_i;
                no_wb_q  <= no_wb_i;
            end
            // A same-cycle preload has already landed, so FETCH sees it
            if (state_q == ST_FETCH) begin
                alu_a_q  <= rs1_data;
                alu_b_q  <= imm_en_q ? imm_q : rs2_data;
                alu_op_q <= op_q;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_c_i;
                flags_q  <= alu_flags_i & FLAG_MASK;
            end
        end
    end

    assign alu_a_o  = alu_a_q;
    assign alu_b_o  = alu_b_q;
    assign alu_op_o = alu_op_q;
    assign result_o = result_q;
    assign flags_o  = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl with a behavioural ALU attached.
// Reference model: array of register values plus an arithmetic ALU function.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [1:0] rd, rs1, rs2;
    logic       imm_en;
    logic [7:0] imm;
    logic       no_wb;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, done;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_c, alu_flags;
    logic [7:0] result, flags;
    logic [15:0] alu_v;

    int passed = 0;
    int total  = 0;
    logic [7:0] ref_regs [4];

    always #5 clk = ~clk;

    alu_exec_ctrl #(.REG_COUNT(4), .ADDR_W(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .op_i        (op),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .imm_en_i    (imm_en),
        .imm_i       (imm),
        .no_wb_i     (no_wb),
        .ld_en_i     (ld_en),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_c_i     (alu_c),
        .alu_flags_i (alu_flags),
        .result_o    (result),
        .flags_o     (flags)
    );

    function automatic int s8(input int x);
        int t;
        t = x & 255;
        return (t > 127) ? t - 256 : t;
    endfunction

    // Returns {flags, result} computed with plain integer arithmetic
    function automatic logic [15:0] alu_ref(input logic [3:0] o,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        int x, y, r, sr;
        bit c, ac, v;
        logic [7:0] q, f;
        x = int'(a);
        y = int'(b);
        r = 0; sr = 0; c = 0; ac = 0;
        case (o)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_NOT: r = 255 - x;
            OP_ADD, OP_INC: begin
                if (o == OP_INC) y = 1;
                r  = x + y;
                c  = (r > 255);
                ac = ((x % 16) + (y % 16)) > 15;
                sr = s8(x) + s8(y);
            end
            OP_SUB, OP_DEC, OP_NEG: begin
                if (o == OP_DEC) y = 1;
                if (o == OP_NEG) begin y = x; x = 0; end
                r  = x - y;
                c  = (x < y);
                ac = (x % 16) < (y % 16);
                sr = s8(x) - s8(y);
            end
            OP_SHL: r = (y > 7) ? 0 : x * (1 << y);
            OP_SHR: r = (y > 7) ? 0 : x / (1 << y);
            OP_MIRROR: begin
                for (int i = 0; i < 8; i++)
                    if (((x >> i) & 1) == 1) r = r + (1 << (7 - i));
            end
            default: r = 0;
        endcase
        v = (sr > 127) || (sr < -128);
        q = 8'(r & 255);
        f = {2'b00, v, ($countones(q) % 2 == 0), q[7], (q == 8'h00), ac, c};
        return {f, q};
    endfunction

    // Stand-in ALU; it drives junk on flag bits [7:6]
    assign alu_v     = alu_ref(alu_op, alu_a, alu_b);
    assign alu_c     = alu_v[7:0];
    assign alu_flags = alu_v[15:8] | 8'hC0;

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        ref_regs[a] = d;
    endtask

    // Issues one instruction from IDLE and watches six cycles.
    // ldm: 0 none, 1 preload together with start, 2 preload while busy.
    task automatic issue(input logic [3:0] o, input logic [1:0] d_, s1, s2,
                         input bit ie, input logic [7:0] im, input bit nwb,
                         input bit repulse, input int ldm,
                         input logic [1:0] la, input logic [7:0] ldv,
                         output int lat, output int ndone,
                         output logic [5:0] bm, output logic [7:0] xf);
        op = o; rd = d_; rs1 = s1; rs2 = s2;
        imm_en = ie; imm = im; no_wb = nwb; start = 1'b1;
        if (ldm == 1) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ldv;
        end
        lat = -1; ndone = 0; bm = '0; xf = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!repulse || k >= 4) start = 1'b0;
            if (ldm == 2 && k <= 3) begin
                ld_en = 1'b1; ld_addr = la; ld_data = ldv;
            end else begin
                ld_en = 1'b0;
            end
            bm[k-1] = busy;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == 2) xf = alu_flags & 8'h3F;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++;
        if ({alu_a, alu_b, alu_op} !== 20'h0)
            $display("FAIL rst_alu_in: got %h want 0", {alu_a, alu_b, alu_op});
        else passed++;
        total++;
        if ({result, flags} !== 16'h0)
            $display("FAIL rst_res_flags: got %h want 0", {result, flags});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ref_regs[i] = 8'h00;
            peek(2'(i), d);
            total++; if (d !== 8'h00) $display("FAIL rst_reg%0d: got %h want 00", i, d); else passed++;
        end
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_and();
        int lat, nd; logic [5:0] bm; logic [7:0] xf, d; logic [15:0] e;
        load(0, 8'hCA);
        load(1, 8'hAA);
        issue(OP_AND, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, lat, nd, bm, xf);
        e = alu_ref(OP_AND, 8'hCA, 8'hAA);
        ref_regs[2] = e[7:0];
        peek(2, d);
        total++; if (lat !== 3) $display("FAIL and_latency: got %0d want 3", lat); else passed++;
        total++; if (bm !== 6'b000111) $display("FAIL and_busy: got %b want 000111", bm); else passed++;
        total++; if (d !== 8'h8A) $display("FAIL and_r2: got %h want 8a", d); else passed++;
        total++; if (result !== 8'h8A) $display("FAIL and_result: got %h want 8a", result); else passed++;
        total++; if (flags !== xf) $display("FAIL and_flags_exec: got %h want %h", flags, xf); else passed++;
        total++; if (flags !== e[15:8]) $display("FAIL and_flags: got %h want %h", flags, e[15:8]); else passed++;
        total++;
        if (flags[FLAG_SIGN] !== 1'b1 || flags[FLAG_ZERO] !== 1'b0)
            $display("FAIL and_sign_zero: got %b%b want 10", flags[FLAG_SIGN], flags[FLAG_ZERO]);
        else passed++;
    endtask

    task automatic test_add();
        int lat, nd; logic [5:0] bm; logic [7:0] xf, d;
        load(0, 8'hCA);
        load(1, 8'hAA);
        issue(OP_ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, lat, nd, bm, xf);
        peek(0, d);
        total++; if (d !== 8'h74) $display("FAIL add_r0: got %h want 74", d); else passed++;
        total++; if (flags[FLAG_CARRY] !== 1'b1) $display("FAIL add_carry: got %b want 1", flags[FLAG_CARRY]); else passed++;
        total++; if (flags[FLAG_OVERFLOW] !== 1'b1) $display("FAIL add_ovf: got %b want 1", flags[FLAG_OVERFLOW]); else passed++;
        total++; if (flags !== xf) $display("FAIL add_flags_exec: got %h want %h", flags, xf); else passed++;
        ref_regs[0] = 8'h74;
        peek(1, d);
        total++; if (d !== 8'hAA) $display("FAIL add_r1: got %h want aa", d); else passed++;
    endtask

    task automatic test_compare();
        int lat, nd; logic [5:0] bm; logic [7:0] xf, d;
        load(0, 8'h05);
        load(1, 8'h05);
        issue(OP_SUB, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, lat, nd, bm, xf);
        peek(0, d);
        total++; if (flags[FLAG_ZERO] !== 1'b1) $display("FAIL cmp_zero: got %b want 1", flags[FLAG_ZERO]); else passed++;
        total++; if (d !== 8'h05) $display("FAIL cmp_r0: got %h want 05", d); else passed++;
        total++; if (nd !== 1) $display("FAIL cmp_done: got %0d want 1", nd); else passed++;
    endtask

    task automatic test_imm_shift();
        int lat, nd; logic [5:0] bm; logic [7:0] xf, d;
        load(3, 8'hCA);
        issue(OP_SHR, 3, 3, 0, 1, 8'd2, 0, 1, 0, 0, 0, lat, nd, bm, xf);
        ref_regs[3] = 8'h32;
        peek(3, d);
        total++; if (d !== 8'h32) $display("FAIL shr_r3: got %h want 32", d); else passed++;
        total++; if (nd !== 1) $display("FAIL shr_one_done: got %0d want 1", nd); else passed++;
        total++; if (bm !== 6'b000111) $display("FAIL shr_busy: got %b want 000111", bm); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, nd, cnt; logic [5:0] bm; logic [7:0] xf, d;
        load(1, 8'h10);
        op = OP_INC; rd = 1; rs1 = 1; rs2 = 0;
        imm_en = 1'b0; imm = 8'h00; no_wb = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({busy, done} !== 2'b00) $display("FAIL rmid_busy_done: got %b want 00", {busy, done}); else passed++;
        total++;
        if ({alu_a, alu_b, alu_op, result, flags} !== 36'h0)
            $display("FAIL rmid_outputs: got %h want 0", {alu_a, alu_b, alu_op, result, flags});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        total++; if (cnt !== 0) $display("FAIL rmid_no_done: got %0d want 0", cnt); else passed++;
        peek(1, d);
        total++; if (d !== 8'h00) $display("FAIL rmid_r1: got %h want 00", d); else passed++;
        issue(OP_INC, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, lat, nd, bm, xf);
        ref_regs[1] = 8'h01;
        peek(1, d);
        total++; if (lat !== 3) $display("FAIL rmid_restart_lat: got %0d want 3", lat); else passed++;
        total++; if (d !== 8'h01) $display("FAIL rmid_restart_r1: got %h want 01", d); else passed++;
    endtask

    task automatic test_ld_start();
        int lat, nd; logic [5:0] bm; logic [7:0] xf, d;
        load(1, 8'h33);
        issue(OP_NOT, 2, 0, 0, 0, 0, 0, 0, 2, 1, 8'h7F, lat, nd, bm, xf);
        ref_regs[2] = 8'hFF - ref_regs[0];
        peek(1, d);
        total++; if (d !== 8'h33) $display("FAIL ld_busy_r1: got %h want 33", d); else passed++;
        issue(OP_NOT, 2, 1, 0, 0, 0, 0, 0, 1, 1, 8'h7F, lat, nd, bm, xf);
        ref_regs[1] = 8'h7F;
        ref_regs[2] = 8'h80;
        total++; if (result !== 8'h80) $display("FAIL ld_start_result: got %h want 80", result); else passed++;
        peek(1, d);
        total++; if (d !== 8'h7F) $display("FAIL ld_start_r1: got %h want 7f", d); else passed++;
        peek(2, d);
        total++; if (d !== 8'h80) $display("FAIL ld_start_r2: got %h want 80", d); else passed++;
    endtask

    task automatic test_random();
        int lat, nd, ldm;
        logic [5:0] bm; logic [7:0] xf, d, im, bv, ldv;
        logic [3:0] o; logic [1:0] a_rd, a_s1, a_s2, la;
        bit ie, nwb;
        logic [15:0] e;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            o    = 4'($urandom_range(0, 11));
            a_rd = 2'($urandom_range(0, 3));
            a_s1 = 2'($urandom_range(0, 3));
            a_s2 = 2'($urandom_range(0, 3));
            ie   = 1'($urandom_range(0, 1));
            im   = 8'($urandom_range(0, 255));
            if (o == OP_SHL || o == OP_SHR) im = 8'($urandom_range(0, 9));
            nwb  = ($urandom_range(0, 3) == 0);
            ldm  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            la   = 2'($urandom_range(0, 3));
            ldv  = 8'($urandom_range(0, 255));
            if (ldm == 1) ref_regs[la] = ldv;
            bv = ie ? im : ref_regs[a_s2];
            e  = alu_ref(o, ref_regs[a_s1], bv);
            issue(o, a_rd, a_s1, a_s2, ie, im, nwb, 0, ldm, la, ldv, lat, nd, bm, xf);
            if (!nwb) ref_regs[a_rd] = e[7:0];
            total++; if (lat !== 3) $display("FAIL rnd%0d_lat: got %0d want 3", it, lat); else passed++;
            total++; if (result !== e[7:0]) $display("FAIL rnd%0d_result op%0d: got %h want %h", it, o, result, e[7:0]); else passed++;
            total++; if (flags !== e[15:8]) $display("FAIL rnd%0d_flags op%0d: got %h want %h", it, o, flags, e[15:8]); else passed++;
            for (int r = 0; r < 4; r++) begin
                peek(2'(r), d);
                total++;
                if (d !== ref_regs[r]) $display("FAIL rnd%0d_r%0d: got %h want %h", it, r, d, ref_regs[r]);
                else passed++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        imm_en = 1'b0; imm = '0; no_wb = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        test_and();
        test_add();
        test_compare();
        test_imm_shift();
        test_reset_mid();
        test_ld_start();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
